data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, number of 32-bit words of backing storage (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-003 Parameter WAIT_STATES, default 1, extra cycles (0..15) inserted before every response.
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port r_req  in  1  read request, held by initiator until r_valid.
REQ-007 Port r_addr  in  32  read byte address, stable while r_req high.
REQ-008 Port r_valid  out  1  one-cycle pulse, r_data/r_err valid.
REQ-009 Port r_data  out  32  read word.
REQ-010 Port r_err  out  1  access fault, qualified by r_valid.
REQ-011 Port w_req  in  1  write request, held until w_done.
REQ-012 Port w_addr  in  32  write byte address, stable while w_req high.
REQ-013 Port w_data  in  32  write data, byte lanes aligned to address bits [1:0]=0.
REQ-014 Port w_strb  in  4  byte enables, bit i writes w_data[8i+7:8i].
REQ-015 Port w_done  out  1  one-cycle pulse, write completed or faulted.
REQ-016 Port w_err  out  1  access fault, qualified by w_done.

Function
REQ-017 FSM states IDLE, WAIT, RESP; one transaction in flight, read or write.
REQ-018 IDLE: w_req high -> latch write, go WAIT (or RESP if WAIT_STATES=0); else r_req high -> latch read, same; else stay.
REQ-019 Simultaneous r_req and w_req in IDLE: write accepted first; read accepted in the IDLE cycle after w_done.
REQ-020 WAIT: 4-bit counter loaded with WAIT_STATES-1 on accept, decrements each cycle; at 0 -> RESP.
REQ-021 RESP: exactly one cycle; asserts r_valid or w_done per latched type; memory write committed on this edge; next state IDLE.
REQ-022 Read latency: request sampled at edge N -> r_valid high during cycle N+1+WAIT_STATES.
REQ-023 After a response, the request line is ignored in the following IDLE cycle if the initiator has not yet dropped it (one dead cycle, prevents double accept).
REQ-024 Word index = (addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS); subtraction modulo 2^32.
REQ-025 Fault when addr[1:0] != 0 or addr - BASE_ADDR >= 4*DEPTH_WORDS (unsigned); faulted read returns r_data=0, faulted write modifies nothing; r_err/w_err=1.
REQ-026 w_strb=4'b0000 is a legal no-op write, w_done pulses, w_err=0.
REQ-027 Read issued after a write to the same word returns post-write data (write committed before read accept).
REQ-028 r_data holds last value between responses; r_valid, w_done, r_err, w_err are 0 outside RESP.
REQ-029 Storage is inferable single-port RAM, uninitialised; no reset of contents.

Reset
REQ-030 rst_n low: FSM to IDLE, counter 0, r_valid=0, w_done=0, r_err=0, w_err=0, r_data=0, immediately (asynchronous).
REQ-031 Reset mid-transaction: transaction dropped, no response pulse, no partial memory write; memory contents preserved.
REQ-032 First request accepted on the first rising edge with rst_n high.

Verification
REQ-033 WAIT_STATES=1: write 0xDEADBEEF strb 4'hF to BASE_ADDR+0x10, then read it -> w_done after 2 cycles, r_valid after 2 cycles, r_data=0xDEADBEEF, errors 0.
REQ-034 Byte strobes: word 0x11223344, write 0xAABBCCDD strb 4'b0101 -> read returns 0x11BB33DD.
REQ-035 r_req and w_req raised same cycle to same word -> w_done first, then r_valid with new data; never both pulses in one cycle.
REQ-036 Read addr BASE_ADDR+0x2 and BASE_ADDR+4*DEPTH_WORDS -> r_valid with r_err=1, r_data=0; write to out-of-range -> w_err=1, memory unchanged.
REQ-037 WAIT_STATES=0 and 15: r_valid exactly 1 and 16 cycles after accept.
REQ-038 Assert rst_n low during WAIT of a write -> no w_done, target word keeps old value, next read serviced normally.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state memory responder, one read or write in flight
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_req,
    input  logic [31:0] r_addr,
    output logic        r_valid,
    output logic [31:0] r_data,
    output logic        r_err,
    input  logic        w_req,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    output logic        w_done,
    output logic        w_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      cnt;
    logic            lat_write;
    logic            lat_fault;
    logic [AW-1:0]   lat_idx;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_strb;
    logic            served_r;
    logic            served_w;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [31:0]     r_off;
    logic [31:0]     w_off;
    logic            r_fault;
    logic            w_fault;
    logic            acc_r;
    logic            acc_w;
    logic            rd_load;
    logic            rd_fault;
    logic [AW-1:0]   rd_idx;

    assign r_off   = r_addr - BASE_ADDR;
    assign w_off   = w_addr - BASE_ADDR;
    assign r_fault = (r_addr[1:0] != 2'b00) || ({1'b0, r_off} >= SPAN);
    assign w_fault = (w_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);

    // served_* masks the line just answered for one IDLE cycle so a still-held request is not taken twice
    always_comb begin
        state_nx = state;
        acc_w    = 1'b0;
        acc_r    = 1'b0;
        case (state)
            IDLE: begin
                if (w_req && !served_w) begin
                    acc_w    = 1'b1;
                    state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
                end else if (r_req && !served_r) begin
                    acc_r    = 1'b1;
                    state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // the read word is fetched on the edge that enters RESP, so r_data only changes with r_valid
    always_comb begin
        rd_load  = 1'b0;
        rd_idx   = lat_idx;
        rd_fault = lat_fault;
        if (state == IDLE) begin
            rd_idx   = r_off[AW+1:2];
            rd_fault = r_fault;
            rd_load  = acc_r && (state_nx == RESP);
        end else if (state == WAIT) begin
            rd_load  = !lat_write && (state_nx == RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_fault <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_strb  <= 4'd0;
            served_r  <= 1'b0;
            served_w  <= 1'b0;
            r_data    <= 32'd0;
        end else begin
            state    <= state_nx;
            served_w <= (state == RESP) && lat_write;
            served_r <= (state == RESP) && !lat_write;
            if (acc_w) begin
                lat_write <= 1'b1;
                lat_fault <= w_fault;
                lat_idx   <= w_off[AW+1:2];
                lat_wdata <= w_data;
                lat_strb  <= w_strb;
                cnt       <= CNT_INIT;
            end else if (acc_r) begin
                lat_write <= 1'b0;
                lat_fault <= r_fault;
                lat_idx   <= r_off[AW+1:2];
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_load) begin
                r_data <= rd_fault ? 32'd0 : mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == RESP && lat_write && !lat_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_strb[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

    assign r_valid = (state == RESP) && !lat_write;
    assign w_done  = (state == RESP) && lat_write;
    assign r_err   = r_valid && lat_fault;
    assign w_err   = w_done && lat_fault;

endmodule
